div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 divider serving the execute stage's `DIV`/`DIVU` requests. It captures operands when the execute stage raises `start`, runs a restoring-division state machine for 32 cycles, and returns `{remainder, quotient}` with a one-cycle `ready` pulse. The execute stage stalls the pipeline while `start` is high and `ready` is low. The result is written into HI/LO downstream.

## Interface
Parameters: none.

- `clk`  in  1  — core clock.
- `rst`  in  1  — reset; asynchronous, active-high.
- `flush`  in  1  — pipeline flush or exception; aborts any operation.
- `start`  in  1  — request; held high by execute until `ready`.
- `signed_div`  in  1  — 1 = `DIV`, 0 = `DIVU`; sampled with `start`.
- `opr1`  in  32  — dividend; sampled with `start`.
- `opr2`  in  32  — divisor; sampled with `start`.
- `ready`  out  1  — result valid; one-cycle pulse.
- `res`  out  64  — `res[63:32]` = remainder (HI), `res[31:0]` = quotient (LO).

## Operation
States: `FREE`, `ON`, `END`.

- **FREE**
  - On `start & !flush`, capture `signed_div`, the magnitude of each operand (magnitude only if `signed_div`), the dividend sign and the quotient sign (dividend sign XOR divisor sign).
  - If the divisor is 0: `res` is all zeros, go to `END`.
  - Otherwise: clear the 64-bit work register to `{32'b0, |opr1|}`, set `cnt` to 0, go to `ON`.
- **ON**, each cycle:
  - Shift the work register left by 1.
  - Compute the 33-bit trial = `work[63:32] − |divisor|`.
  - If trial ≥ 0, load `work[63:32]` with the trial and set `work[0]` to 1.
  - Increment `cnt`. When `cnt` is 31, go to `END` and load `res`:
    - Quotient is `work[31:0]`, two's-complement negated if signed and the quotient sign is set.
    - Remainder is `work[63:32]`, negated if signed and the dividend was negative.
- **END**
  - `ready` = 1 (decoded from state, not masked by `flush`).
  - Go to `FREE` unconditionally.
- **Flush**: in any state, `flush` forces `FREE` next cycle. `res` is not updated by an aborted operation. `flush` has priority over `start`.
- **Operands**: changes to `opr1`, `opr2` or `signed_div` after capture are ignored.
- **Back-to-back**: `start` high in the cycle after `END` begins a new operation from `FREE`.
- **Overflow case**: `0x80000000 / 0xFFFFFFFF` (signed) gives quotient `0x80000000`, remainder 0. This follows from the magnitude arithmetic and needs no special case.

## Timing
- Reset values: state `FREE`, `ready` 0, `res` 0, `cnt` 0, work register 0.
- Normal latency: `start` sampled in cycle 0; `ON` occupies cycles 1–32; `ready` is high in cycle 33.
- Divide by zero: `ready` is high in cycle 1.
- `ready` is registered-state decoded and high for exactly one cycle.
- `res` is stable from the `ready` cycle until the next capture.
- Reset asserted mid-operation returns every register to its reset value immediately; no `ready` is produced.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In `FREE`, if `|dividend| < |divisor|` and the divisor is nonzero, skip `ON`.
  - Load quotient 0 and remainder = the original `opr1`, then go to `END`.
  - `ready` is high in cycle 1.
- `DIV_EARLY_OUT_EN` undefined: always iterate 32 cycles, giving identical results with normal latency.

## Structure
- Shared defines/package holds:
  - state encodings `DivFree`, `DivOn`, `DivEnd` (2-bit);
  - the `DWord` 64-bit bus and `Word` bus macros;
  - `ZeroWord`.
- No sub-module. The trial subtraction and sign fix-up are inline combinational logic in `div_unit`.
- The execute stage connects `div_start` → `start`, `div_signed` → `signed_div`, `div_ready` ← `ready`.

## Test plan
- DIVU `100 / 7` → `ready` in cycle 33; `res = {32'd2, 32'd14}`.
- DIV `0xFFFFFFF9 (−7) / 2` → quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`; DIV `7 / −2` → quotient `0xFFFFFFFD`, remainder `1`.
- DIV `0x80000000 / 0xFFFFFFFF` → quotient `0x80000000`, remainder 0.
- Divisor 0 (`opr1 = 5`) → `ready` in cycle 1, `res = 0`; `DIV_EARLY_OUT_EN` build with DIVU `3 / 9` → `ready` in cycle 1, `res = {32'd3, 32'd0}`.
- `flush` in cycle 10 of `ON` → `FREE` next cycle, no `ready`, `res` unchanged. `rst` pulsed in cycle 20 → `ready` 0, `res` 0.
- `start` held high for two consecutive DIVU ops (`50 / 5`, then `9 / 4`) → `ready` pulses in cycles 33 and 67, results 10/0 then 2/1.

Source files
------------

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//
// Shared definitions for the iterative divider:
//   - `Word / `DWord     : bit-range macros for 32-bit and 64-bit buses
//   - word_t / dword_t   : bus typedefs built from those ranges
//   - ZeroWord           : all-zero 32-bit constant
//   - div_state_e        : 2-bit FSM encoding (DivFree, DivOn, DivEnd)
//   - DivLastIter        : value of the iteration counter on the last ON cycle
//   - mag()              : operand magnitude, honouring the signed/unsigned mode
// -----------------------------------------------------------------------------
`ifndef DIV_UNIT_PKG_MACROS
`define DIV_UNIT_PKG_MACROS
`define Word  31:0
`define DWord 63:0
`endif

package div_unit_pkg;

    typedef logic [`Word]  word_t;
    typedef logic [`DWord] dword_t;

    localparam word_t  ZeroWord  = 32'h0000_0000;
    localparam dword_t ZeroDWord = 64'h0;

    typedef enum logic [1:0] {
        DivFree = 2'b00,
        DivOn   = 2'b01,
        DivEnd  = 2'b10
    } div_state_e;

    // 32 shift/subtract steps, counter runs 0..31
    localparam logic [4:0] DivLastIter = 5'd31;

    // Two's-complement magnitude when the operation is signed; 0x80000000
    // maps to itself, which is the correct unsigned magnitude 2^31.
    function automatic word_t mag(input word_t v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic word_t neg_if(input word_t v, input logic do_neg);
        return do_neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
//
// Request/response bundle between the execute stage (master) and the
// iterative divider (slave).
//   flush       : pipeline flush / exception, aborts any operation
//   start       : request, held high by execute until ready
//   signed_div  : 1 = DIV, 0 = DIVU, sampled with start
//   opr1        : dividend, sampled with start
//   opr2        : divisor, sampled with start
//   ready       : one-cycle result-valid pulse
//   res         : {remainder, quotient}
// -----------------------------------------------------------------------------
interface div_unit_if;
    import div_unit_pkg::*;

    logic   flush;
    logic   start;
    logic   signed_div;
    word_t  opr1;
    word_t  opr2;
    logic   ready;
    dword_t res;

    modport master (
        output flush,
        output start,
        output signed_div,
        output opr1,
        output opr2,
        input  ready,
        input  res
    );

    modport slave (
        input  flush,
        input  start,
        input  signed_div,
        input  opr1,
        input  opr2,
        output ready,
        output res
    );

endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider for DIV/DIVU. Operands are captured
// when start is seen in FREE; the magnitudes are divided over 32 ON cycles
// and the signs are re-applied when the result is loaded into res.
//
// Ports:
//   clk  : core clock
//   rst  : asynchronous, active-high reset
//   bus  : div_unit_if.slave (flush, start, signed_div, opr1, opr2 in;
//          ready, res out). res[63:32] = remainder (HI), res[31:0] = quotient (LO)
//
// Build option:
//   DIV_EARLY_OUT_EN : when defined, a dividend whose magnitude is below the
//                      divisor's magnitude skips ON and completes in one cycle
//                      with quotient 0 and remainder = opr1.
//
// state    | meaning
// ---------+----------------------------------------------------------
// DivFree  | idle, waiting for start
// DivOn    | one shift/trial-subtract step per cycle, cnt = 0..31
// DivEnd   | res valid, ready high for this single cycle
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    div_state_e state;
    logic [4:0] cnt;
    dword_t     work;
    word_t      dvs_mag;
    logic       rem_neg;
    logic       quot_neg;
    dword_t     res_q;

    word_t      a_mag;
    word_t      b_mag;
    logic       early_out;

    dword_t     shifted;
    logic [32:0] trial;
    dword_t     work_step;
    word_t      quot_fix;
    word_t      rem_fix;

    assign a_mag = mag(bus.opr1, bus.signed_div);
    assign b_mag = mag(bus.opr2, bus.signed_div);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (a_mag < b_mag);
`else
    assign early_out = 1'b0;
`endif

    // One restoring step. The partial remainder never exceeds 31 significant
    // bits before the shift, so the shifted upper half always fits in 32 bits
    // and the sign of the 33-bit trial alone decides the quotient bit.
    always_comb begin
        shifted   = {work[62:0], 1'b0};
        trial     = {1'b0, shifted[63:32]} - {1'b0, dvs_mag};
        work_step = shifted;
        if (!trial[32]) begin
            work_step[63:32] = trial[31:0];
            work_step[0]     = 1'b1;
        end
    end

    assign quot_fix = neg_if(work_step[31:0],  quot_neg);
    assign rem_fix  = neg_if(work_step[63:32], rem_neg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= 5'd0;
            work     <= ZeroDWord;
            dvs_mag  <= ZeroWord;
            rem_neg  <= 1'b0;
            quot_neg <= 1'b0;
            res_q    <= ZeroDWord;
        end else if (bus.flush) begin
            // Abort leaves res untouched so HI/LO keep the last good result.
            state <= DivFree;
        end else begin
            unique case (state)
                DivFree: begin
                    if (bus.start) begin
                        dvs_mag  <= b_mag;
                        rem_neg  <= bus.signed_div & bus.opr1[31];
                        quot_neg <= bus.signed_div & (bus.opr1[31] ^ bus.opr2[31]);
                        if (bus.opr2 == ZeroWord) begin
                            res_q <= ZeroDWord;
                            state <= DivEnd;
                        end else if (early_out) begin
                            res_q <= {bus.opr1, ZeroWord};
                            state <= DivEnd;
                        end else begin
                            work  <= {ZeroWord, a_mag};
                            cnt   <= 5'd0;
                            state <= DivOn;
                        end
                    end
                end
                DivOn: begin
                    work <= work_step;
                    cnt  <= cnt + 5'd1;
                    if (cnt == DivLastIter) begin
                        res_q <= {rem_fix, quot_fix};
                        state <= DivEnd;
                    end
                end
                DivEnd: begin
                    state <= DivFree;
                end
                default: begin
                    state <= DivFree;
                end
            endcase
        end
    end

    assign bus.ready = (state == DivEnd);
    assign bus.res   = res_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if bus();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          exp_ready_cyc = -1;
    logic [63:0] exp_res = 64'd0;
    logic [63:0] exp_lit = 64'd0;
    bit          lit_valid = 1'b0;
    logic [63:0] res_model;

    function automatic longint unsigned tb_mag(input bit sgn, input logic [31:0] v);
        return (sgn && v[31]) ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    endfunction

    // Reference: divide the magnitudes with plain integer arithmetic and
    // re-apply signs (quotient: XOR of operand signs, remainder: dividend sign).
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        logic [31:0] qo, ro;
        if (b == 32'd0) return 64'd0;
        ma = tb_mag(sgn, a);
        mb = tb_mag(sgn, b);
        q  = ma / mb;
        r  = ma % mb;
        qo = q[31:0];
        ro = r[31:0];
        if (sgn && (a[31] ^ b[31])) qo = 32'd0 - qo;
        if (sgn && a[31])           ro = 32'd0 - ro;
        return {ro, qo};
    endfunction

    function automatic int latency(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (tb_mag(sgn, a) < tb_mag(sgn, b)) return 1;
`endif
        return 33;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Single compare process: pins the model with literals, then checks
    // ready and res on every cycle against the model-derived expectation.
    initial begin
        res_model = 64'd0;
        check("model_divu_100_7",    model(1'b0, 32'd100, 32'd7),                {32'd2, 32'd14});
        check("model_div_m7_2",      model(1'b1, 32'hFFFF_FFF9, 32'd2),          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("model_div_7_m2",      model(1'b1, 32'd7, 32'hFFFF_FFFE),          {32'd1, 32'hFFFF_FFFD});
        check("model_div_overflow",  model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF),  {32'd0, 32'h8000_0000});
        check("model_div_by_zero",   model(1'b0, 32'd5, 32'd0),                  64'd0);
        check("model_divu_3_9",      model(1'b0, 32'd3, 32'd9),                  {32'd3, 32'd0});
        forever begin
            @(negedge clk);
            #1;
            if (rst) res_model = 64'd0;
            else if (cyc == exp_ready_cyc) res_model = exp_res;
            check("ready", {63'd0, bus.ready}, {63'd0, ((cyc == exp_ready_cyc) && !rst)});
            check("res", bus.res, res_model);
            if ((cyc == exp_ready_cyc) && lit_valid)
                check("res_literal", bus.res, exp_lit);
        end
    end

    task automatic scramble();
        bus.opr1       = $urandom;
        bus.opr2       = $urandom;
        bus.signed_div = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] lit, input bit keep);
        @(negedge clk);
        bus.flush      = 1'b0;
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.opr1       = a;
        bus.opr2       = b;
        exp_res        = model(sgn, a, b);
        exp_lit        = lit;
        lit_valid      = 1'b1;
        exp_ready_cyc  = cyc + latency(sgn, a, b);
        while (cyc < exp_ready_cyc) begin
            @(negedge clk);
            scramble();
        end
        if (!keep) bus.start = 1'b0;
    endtask

    task automatic begin_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.flush      = 1'b0;
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opr1       = a;
        bus.opr2       = b;
        exp_res        = model(1'b0, a, b);
        lit_valid      = 1'b0;
        exp_ready_cyc  = cyc + latency(1'b0, a, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opr1       = 32'd0;
        bus.opr2       = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        do_op(1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 1'b0);
        do_op(1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        do_op(1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD}, 1'b0);
        do_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000}, 1'b0);
        do_op(1'b0, 32'd5,          32'd0,          64'd0, 1'b0);
        do_op(1'b0, 32'd3,          32'd9,          {32'd3, 32'd0}, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}, 1'b0);
        do_op(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14}, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0, 32'd1}, 1'b0);
        do_op(1'b1, 32'h8000_0000,  32'd2,          {32'd0, 32'hC000_0000}, 1'b0);
        do_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0}, 1'b0);
        do_op(1'b0, 32'd0,          32'd7,          64'd0, 1'b0);

        // flush wins over start in FREE: capture must slip by one cycle
        @(negedge clk);
        bus.flush      = 1'b1;
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opr1       = 32'd50;
        bus.opr2       = 32'd5;
        lit_valid      = 1'b0;
        exp_ready_cyc  = -1;
        do_op(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0);

        // flush in ON cycle 10, then a new op in the very next cycle
        begin_op(32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        bus.flush     = 1'b1;
        bus.start     = 1'b0;
        exp_ready_cyc = -1;
        do_op(1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 1'b0);

        // reset in ON cycle 20
        begin_op(32'd12345, 32'd67);
        repeat (20) @(negedge clk);
        rst           = 1'b1;
        bus.start     = 1'b0;
        exp_ready_cyc = -1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // back-to-back with start held high
        do_op(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b1);
        do_op(1'b0, 32'd9,  32'd4, {32'd1, 32'd2},  1'b0);

        repeat (5) @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
